pulse_scheduler: RTL and testbench

- Shares one pulse-train generator between NREQ requesters using round-robin arbitration.
- Each requester supplies its own delay, pulse width and pulse count. The granted requester's configuration is latched and the block sequences delay -> high/low pulse train -> done.
- Sits between request sources (trigger-style enables) and the single shared pulse output line.

---
 rtl/pulse_sched_pkg.sv | 30 +++
 rtl/pulse_scheduler_rr_arbiter.sv | 39 +++
 rtl/pulse_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_pulse_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pulse_sched_pkg.sv
// Shared definitions for the round-robin pulse scheduler.
// Provides the FSM state type, the default sizing constants and a helper
// that extracts one requester's field from a packed per-requester bus.
package pulse_sched_pkg;

    localparam int NREQ_DEF = 2;    // default number of requesters
    localparam int DW_DEF   = 8;    // default delay/width field width
    localparam int CW_DEF   = 4;    // default pulse-count field width
    localparam int FIELD_W  = 256;  // widest packed cfg bus the helper accepts

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_HIGH = 3'd2,
        ST_LOW  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Return field number idx (each width bits wide) of a packed bus, zero-extended.
    function automatic logic [31:0] field_get(input logic [FIELD_W-1:0] bus,
                                              input int                 idx,
                                              input int                 width);
        logic [FIELD_W-1:0] mask_s;
        logic [FIELD_W-1:0] shifted_s;
        mask_s    = (FIELD_W'(1'b1) << width) - FIELD_W'(1'b1);
        shifted_s = bus >> (idx * width);
        field_get = 32'(shifted_s & mask_s);
    endfunction

endpackage

// File: rtl/pulse_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req   - request vector, one bit per requester
//   last  - index of the requester served most recently
//   gnt   - one-hot grant for the winner (all zero when no request)
//   idx   - binary index of the winner
//   valid - at least one request present
// The search starts one position after 'last' and wraps around, so the
// requester just served has the lowest priority next time.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    // Rotating-priority search for the first active request after 'last'
    always_comb begin
        gnt   = {NREQ{1'b0}};
        idx   = {IW{1'b0}};
        valid = 1'b0;
        for (int off = 1; off <= NREQ; off++) begin
            int cand;
            cand = (int'(last) + off) % NREQ;
            if (!valid && req[cand[IW-1:0]]) begin
                gnt[cand[IW-1:0]] = 1'b1;
                idx               = cand[IW-1:0];
                valid             = 1'b1;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/pulse_scheduler.sv
// Shared pulse-train generator with round-robin access.
// Ports:
//   clock      - system clock, all logic on posedge
//   reset      - synchronous active-high reset
//   req        - level requests, one bit per requester
//   cfg_delay  - per-requester delay D   (requester i at [i*DW +: DW])
//   cfg_width  - per-requester phase length W (0 behaves as 1)
//   cfg_count  - per-requester pulse count C  (0 behaves as 1)
//   cancel     - abort the running transaction
//   grant      - one-hot owner of the current transaction
//   busy       - transaction in progress
//   signal     - shared pulse output
//   done       - one-cycle completion/abort strobe
// All outputs are registered and equal to what the state register holds,
// so 'signal' is high exactly while the FSM sits in HIGH and 'done' while
// it sits in DONE.
module pulse_scheduler
    import pulse_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF,
    parameter int CW   = CW_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*DW-1:0] cfg_delay,
    input  logic [NREQ*DW-1:0] cfg_width,
    input  logic [NREQ*CW-1:0] cfg_count,
    input  logic             cancel,
    output logic [NREQ-1:0]  grant,
    output logic             busy,
    output logic             signal,
    output logic             done
);

    localparam int              IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [DW-1:0]   DW_ZERO   = {DW{1'b0}};
    localparam logic [DW-1:0]   DW_ONE    = DW'(1'b1);
    localparam logic [CW-1:0]   CW_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0]   CW_ONE    = CW'(1'b1);
    localparam logic [IW-1:0]   PTR_RESET = IW'(NREQ - 1);

    state_t          state_r, state_n;
    logic [DW-1:0]   phase_r, phase_n;
    logic [DW-1:0]   width_r, width_n;
    logic [CW-1:0]   pulses_r, pulses_n;
    logic [IW-1:0]   owner_r, owner_n;
    logic [IW-1:0]   last_r, last_n;
    logic [NREQ-1:0] grant_r, grant_n;
    logic            busy_r, busy_n;
    logic            signal_r;
    logic            done_r;

    logic [NREQ-1:0] arb_gnt_s;
    logic [IW-1:0]   arb_idx_s;
    logic            arb_valid_s;
    logic [DW-1:0]   sel_delay_s;
    logic [DW-1:0]   sel_width_s;
    logic [CW-1:0]   sel_count_s;
    logic [DW-1:0]   eff_width_s;
    logic [CW-1:0]   eff_count_s;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req   (req),
        .last  (last_r),
        .gnt   (arb_gnt_s),
        .idx   (arb_idx_s),
        .valid (arb_valid_s)
    );

    assign sel_delay_s = DW'(field_get(FIELD_W'(cfg_delay), int'(arb_idx_s), DW));
    assign sel_width_s = DW'(field_get(FIELD_W'(cfg_width), int'(arb_idx_s), DW));
    assign sel_count_s = CW'(field_get(FIELD_W'(cfg_count), int'(arb_idx_s), CW));
    assign eff_width_s = (sel_width_s == DW_ZERO) ? DW_ONE : sel_width_s;
    assign eff_count_s = (sel_count_s == CW_ZERO) ? CW_ONE : sel_count_s;

    // Next-state, counter and owner logic of the sequencing FSM
    always_comb begin
        state_n  = state_r;
        phase_n  = phase_r;
        width_n  = width_r;
        pulses_n = pulses_r;
        owner_n  = owner_r;
        last_n   = last_r;
        grant_n  = grant_r;
        busy_n   = busy_r;
        case (state_r)
            ST_IDLE: begin
                if (arb_valid_s) begin
                    // WAIT always spans the acceptance cycle plus D cycles,
                    // so the first rise lands one edge after D expires.
                    state_n  = ST_WAIT;
                    phase_n  = sel_delay_s;
                    width_n  = eff_width_s;
                    pulses_n = eff_count_s;
                    owner_n  = arb_idx_s;
                    grant_n  = arb_gnt_s;
                    busy_n   = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cancel) begin
                    state_n = ST_DONE;
                end else if (phase_r == DW_ZERO) begin
                    state_n = ST_HIGH;
                    phase_n = width_r;
                end else begin
                    phase_n = phase_r - DW_ONE;
                end
            end
            ST_HIGH: begin
                if (cancel) begin
                    state_n = ST_DONE;
                end else if (phase_r <= DW_ONE) begin
                    if (pulses_r <= CW_ONE) begin
                        state_n  = ST_DONE;
                        pulses_n = CW_ZERO;
                    end else begin
                        state_n  = ST_LOW;
                        phase_n  = width_r;
                        pulses_n = pulses_r - CW_ONE;
                    end
                end else begin
                    phase_n = phase_r - DW_ONE;
                end
            end
            ST_LOW: begin
                if (cancel) begin
                    state_n = ST_DONE;
                end else if (phase_r <= DW_ONE) begin
                    state_n = ST_HIGH;
                    phase_n = width_r;
                end else begin
                    phase_n = phase_r - DW_ONE;
                end
            end
            ST_DONE: begin
                state_n  = ST_IDLE;
                phase_n  = DW_ZERO;
                pulses_n = CW_ZERO;
                grant_n  = {NREQ{1'b0}};
                busy_n   = 1'b0;
                last_n   = owner_r;
            end
            default: begin
                state_n  = ST_IDLE;
                phase_n  = DW_ZERO;
                pulses_n = CW_ZERO;
                grant_n  = {NREQ{1'b0}};
                busy_n   = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            phase_r  <= DW_ZERO;
            width_r  <= DW_ZERO;
            pulses_r <= CW_ZERO;
            owner_r  <= {IW{1'b0}};
            last_r   <= PTR_RESET;
            grant_r  <= {NREQ{1'b0}};
            busy_r   <= 1'b0;
            signal_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_n;
            phase_r  <= phase_n;
            width_r  <= width_n;
            pulses_r <= pulses_n;
            owner_r  <= owner_n;
            last_r   <= last_n;
            grant_r  <= grant_n;
            busy_r   <= busy_n;
            signal_r <= (state_n == ST_HIGH);
            done_r   <= (state_n == ST_DONE);
        end
    end

    assign grant  = grant_r;
    assign busy   = busy_r;
    assign signal = signal_r;
    assign done   = done_r;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed self-checking bench for pulse_scheduler (NREQ=2, DW=8, CW=4).
module tb_pulse_scheduler;

    localparam int NREQ = 2;
    localparam int DW   = 8;
    localparam int CW   = 4;

    logic               clock;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] cfg_delay;
    logic [NREQ*DW-1:0] cfg_width;
    logic [NREQ*CW-1:0] cfg_count;
    logic               cancel;
    logic [NREQ-1:0]    grant;
    logic               busy;
    logic               signal;
    logic               done;

    int passed;
    int total;

    logic [31:0] sv, dv, bv, g0v, g1v;

    pulse_scheduler #(
        .NREQ (NREQ),
        .DW   (DW),
        .CW   (CW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .cfg_delay (cfg_delay),
        .cfg_width (cfg_width),
        .cfg_count (cfg_count),
        .cancel    (cancel),
        .grant     (grant),
        .busy      (busy),
        .signal    (signal),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_cfg(input int i, input int d, input int w, input int c);
        cfg_delay[i*DW +: DW] = DW'(d);
        cfg_width[i*DW +: DW] = DW'(w);
        cfg_count[i*CW +: CW] = CW'(c);
    endtask

    // Sample n consecutive edges; bit k of each vector is the value after edge k.
    task automatic capture(input int n, output logic [31:0] s, output logic [31:0] d,
                           output logic [31:0] b, output logic [31:0] g0,
                           output logic [31:0] g1);
        s = 32'd0; d = 32'd0; b = 32'd0; g0 = 32'd0; g1 = 32'd0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            s[i[4:0]]  = signal;
            d[i[4:0]]  = done;
            b[i[4:0]]  = busy;
            g0[i[4:0]] = grant[0];
            g1[i[4:0]] = grant[1];
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(posedge clock); #1;
            n = n + 1;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        int rise;
        int done_at;
        passed    = 0;
        total     = 0;
        reset     = 1'b1;
        req       = 2'b00;
        cancel    = 1'b0;
        cfg_delay = 16'h0000;
        cfg_width = 16'h0000;
        cfg_count = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_grant",  32'(grant),  32'd0);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_signal", 32'(signal), 32'd0);
        chk("rst_done",   32'(done),   32'd0);
        reset = 1'b0;

        // Single train: D=2 W=3 C=2, rises 3/9, falls 6/12, done 12, idle 13
        set_cfg(0, 2, 3, 2);
        req = 2'b01;
        capture(14, sv, dv, bv, g0v, g1v);
        req = 2'b00;
        chk("t1_signal", sv,  32'h0E38);
        chk("t1_done",   dv,  32'h1000);
        chk("t1_busy",   bv,  32'h1FFF);
        chk("t1_grant0", g0v, 32'h1FFF);

        // Zero config: one pulse high A+1..A+2, done A+2, idle A+3
        set_cfg(0, 0, 0, 0);
        req = 2'b01;
        capture(4, sv, dv, bv, g0v, g1v);
        req = 2'b00;
        chk("t2_signal", sv, 32'h2);
        chk("t2_done",   dv, 32'h4);
        chk("t2_busy",   bv, 32'h7);

        // Config stability: W changed 3->7 during WAIT must not matter
        set_cfg(0, 3, 3, 1);
        req = 2'b01;
        sv = 32'd0;
        dv = 32'd0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clock); #1;
            sv[i[4:0]] = signal;
            dv[i[4:0]] = done;
            if (i == 1) cfg_width[7:0] = 8'd7;
        end
        req = 2'b00;
        chk("t3_signal", sv, 32'h70);
        chk("t3_done",   dv, 32'h80);

        // Cancel during second cycle of first HIGH; pending req1 wins next
        set_cfg(0, 1, 4, 3);
        set_cfg(1, 1, 1, 1);
        req = 2'b01;
        @(posedge clock); #1;
        chk("t4_grant_first", 32'(grant), 32'd1);
        req = 2'b11;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("t4_high", 32'(signal), 32'd1);
        @(posedge clock); #1;
        cancel = 1'b1;
        @(posedge clock); #1;
        cancel = 1'b0;
        chk("t4_cancel_signal", 32'(signal), 32'd0);
        chk("t4_cancel_done",   32'(done),   32'd1);
        chk("t4_cancel_busy",   32'(busy),   32'd1);
        @(posedge clock); #1;
        chk("t4_idle_state", {29'd0, grant, busy}, 32'd0);
        chk("t4_idle_done",  32'(done), 32'd0);
        @(posedge clock); #1;
        chk("t4_grant_next", 32'(grant), 32'd2);
        req = 2'b00;
        wait_idle("t4_wait_idle");

        // Reset while in LOW: everything clears with no done strobe
        set_cfg(0, 2, 3, 2);
        req = 2'b01;
        @(posedge clock); #1;
        chk("t5_grant", 32'(grant), 32'd1);
        repeat (6) @(posedge clock);
        #1;
        chk("t5_low_signal", 32'(signal), 32'd0);
        chk("t5_low_busy",   32'(busy),   32'd1);
        reset = 1'b1;
        req   = 2'b11;
        set_cfg(0, 1, 1, 1);
        set_cfg(1, 1, 1, 1);
        @(posedge clock); #1;
        chk("t5_reset_outputs", {28'd0, grant, busy, signal}, 32'd0);
        chk("t5_reset_done",    32'(done), 32'd0);
        reset = 1'b0;

        // Contention with req=11 held: grants 01, 10, 01 spaced F+2
        capture(12, sv, dv, bv, g0v, g1v);
        req = 2'b00;
        chk("t6_grant0", g0v, 32'h0C0F);
        chk("t6_grant1", g1v, 32'h01E0);
        chk("t6_signal", sv,  32'h0084);
        chk("t6_done",   dv,  32'h0108);
        wait_idle("t6_wait_idle");

        // Maximum delay honoured exactly: rise at A+256, done at A+257
        set_cfg(0, 255, 1, 1);
        req     = 2'b01;
        rise    = -1;
        done_at = -1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clock); #1;
            if (i == 0) req = 2'b00;
            if (signal === 1'b1 && rise < 0) rise = i;
            if (done === 1'b1 && done_at < 0) done_at = i;
        end
        chk("t7_max_delay_rise", 32'(rise),    32'd256);
        chk("t7_max_delay_done", 32'(done_at), 32'd257);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
